// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  lcd_pkg : shared LCD raster geometry and DISPSTAT bit positions
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int H_VISIBLE = 240;
  localparam int H_TOTAL   = 308;
  localparam int V_VISIBLE = 160;
  localparam int V_TOTAL   = 228;

  localparam int DS_VBLANK    = 0;
  localparam int DS_HBLANK    = 1;
  localparam int DS_MATCH     = 2;
  localparam int DS_EN_VBLANK = 3;
  localparam int DS_EN_HBLANK = 4;
  localparam int DS_EN_VCOUNT = 5;
  localparam int DS_LYC_LSB   = 8;
  localparam int DS_LYC_MSB   = 15;

  typedef logic [8:0] dot_t;
  typedef logic [7:0] line_t;

  // Field order mirrors DISPSTAT bits 5:3.
  typedef struct packed {
    logic vcount;
    logic hblank;
    logic vblank;
  } irq_en_t;

  // The last line of the frame is not reported as blanking.
  function automatic logic in_vblank(line_t line);
    return (line >= line_t'(V_VISIBLE)) && (line <= line_t'(V_TOTAL - 2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
//  tick_div : free-running divider, one-cycle tick on every TICK_DIV-th clock
//  Revision : 1.0 - initial release
// ============================================================================
module tick_div #(
  parameter int TICK_DIV = 3
) (
  input  logic clk_mem,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_timing.sv
`default_nettype none
// ============================================================================
//  lcd_timing : 308x228 raster counters, blanking flags, DISPSTAT and IRQs.
//  LCD_VCOUNT_IRQ_EN enables the lyc compare and irq_vcount.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_timing
  import lcd_pkg::*;
#(
  parameter int TICK_DIV  = 3,
  parameter int DOT_TICKS = 4
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic [15:0] dispcnt,
  input  logic        dispstat_wr,
  input  logic [15:0] dispstat_wdata,
  output logic [15:0] dispstat,
  output logic [7:0]  vcount,
  output logic [8:0]  hcount,
  output logic        hblank,
  output logic        vblank,
  output logic        pixel_en,
  output logic        irq_vblank,
  output logic        irq_hblank,
  output logic        irq_vcount
);

  localparam int DW = (DOT_TICKS > 1) ? $clog2(DOT_TICKS) : 1;

  logic          tick;
  logic [DW-1:0] dot_q, dot_d;
  dot_t          hcount_q, hcount_d;
  line_t         vcount_q, vcount_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  irq_en_t       en_q, en_d;
  logic          irq_vblank_q, irq_vblank_d;
  logic          irq_hblank_q, irq_hblank_d;
  logic          irq_vcount_q, irq_vcount_d;
  logic          dot_adv, line_adv;
  logic          vcount_match;
  line_t         lyc_q;
  logic          unused_dispcnt;
  logic          unused_wdata;

  tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk_mem (clk_mem),
    .reset   (reset),
    .tick    (tick)
  );

  always_comb begin
    dot_d    = dot_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    dot_adv  = 1'b0;
    line_adv = 1'b0;
    if (tick) begin
      if (dot_q == DW'(DOT_TICKS - 1)) begin
        dot_d   = '0;
        dot_adv = 1'b1;
      end else begin
        dot_d = dot_q + DW'(1);
      end
    end
    if (dot_adv) begin
      if (hcount_q == dot_t'(H_TOTAL - 1)) begin
        hcount_d = '0;
        line_adv = 1'b1;
        vcount_d = (vcount_q == line_t'(V_TOTAL - 1)) ? '0 : vcount_q + 8'd1;
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
    end
    // Flags follow the next counter values so they change in the same cycle.
    hblank_d = (hcount_d >= dot_t'(H_VISIBLE));
    vblank_d = in_vblank(vcount_d);

    en_d = en_q;
    if (dispstat_wr) begin
      en_d = irq_en_t'(dispstat_wdata[DS_EN_VCOUNT:DS_EN_VBLANK]);
    end
`ifndef LCD_VCOUNT_IRQ_EN
    en_d.vcount = 1'b0;
`endif
    irq_vblank_d = en_d.vblank && line_adv && (vcount_q == line_t'(V_VISIBLE - 1));
    irq_hblank_d = en_d.hblank && dot_adv && (hcount_q == dot_t'(H_VISIBLE - 1));
  end

`ifdef LCD_VCOUNT_IRQ_EN
  line_t lyc_d;

  // A write landing on a line change is compared against the new line.
  always_comb begin
    lyc_d        = dispstat_wr ? dispstat_wdata[DS_LYC_MSB:DS_LYC_LSB] : lyc_q;
    irq_vcount_d = en_d.vcount && (vcount_d == lyc_d) && (vcount_q != lyc_q);
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      lyc_q <= '0;
    end else begin
      lyc_q <= lyc_d;
    end
  end

  assign vcount_match = (vcount_q == lyc_q);
  assign unused_wdata = ^{dispstat_wdata[7:6], dispstat_wdata[2:0]};
`else
  assign lyc_q        = '0;
  assign irq_vcount_d = 1'b0;
  assign vcount_match = 1'b0;
  assign unused_wdata = ^{dispstat_wdata[15:6], dispstat_wdata[2:0]};
`endif

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      dot_q        <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      en_q         <= '0;
      irq_vblank_q <= 1'b0;
      irq_hblank_q <= 1'b0;
      irq_vcount_q <= 1'b0;
    end else begin
      dot_q        <= dot_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hblank_q     <= hblank_d;
      vblank_q     <= vblank_d;
      en_q         <= en_d;
      irq_vblank_q <= irq_vblank_d;
      irq_hblank_q <= irq_hblank_d;
      irq_vcount_q <= irq_vcount_d;
    end
  end

  assign unused_dispcnt = ^{dispcnt[15:8], dispcnt[6:0]};

  assign dispstat   = {lyc_q, 2'b00, en_q, vcount_match, hblank_q, vblank_q};
  assign vcount     = vcount_q;
  assign hcount     = hcount_q;
  assign hblank     = hblank_q;
  assign vblank     = vblank_q;
  assign pixel_en   = !hblank_q && !vblank_q && !dispcnt[7];
  assign irq_vblank = irq_vblank_q;
  assign irq_hblank = irq_hblank_q;
  assign irq_vcount = irq_vcount_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing.sv
`default_nettype none
// ============================================================================
//  tb_lcd_timing : randomized self-checking bench with a position-from-cycle
//  reference model. Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing;

`ifdef LCD_VCOUNT_IRQ_EN
  localparam bit VC_EN = 1'b1;
`else
  localparam bit VC_EN = 1'b0;
`endif
  localparam int FRAME = 308 * 228;
  localparam int N_RST = 170 * 308 + 7;

  logic        clk_mem = 1'b0;
  logic        reset_a, reset_b;
  logic [15:0] dispcnt;
  logic        dispstat_wr;
  logic [15:0] dispstat_wdata;

  logic [15:0] f_ds, d_ds, r_ds;
  logic [7:0]  f_v, d_v, r_v;
  logic [8:0]  f_h, d_h, r_h;
  logic        f_hb, f_vb, f_pix, f_iv, f_ih, f_ic;
  logic        d_hb, d_vb, d_pix, d_iv, d_ih, d_ic;
  logic        r_hb, r_vb, r_pix, r_iv, r_ih, r_ic;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [7:0]  m_lyc;
  logic [2:0]  m_en;
  int          p_h, p_v;
  logic        p_match;
  logic        p_wr;
  logic [15:0] p_wd;
  int          n_w50;
  int          cnt_iv, cnt_ih, cnt_ic, cnt_pix, cnt_l100, cnt_rirq;

  always #5 clk_mem = ~clk_mem;

  lcd_timing #(.TICK_DIV(1), .DOT_TICKS(1)) u_fast (
    .clk_mem(clk_mem), .reset(reset_a), .dispcnt(dispcnt), .dispstat_wr(dispstat_wr),
    .dispstat_wdata(dispstat_wdata), .dispstat(f_ds), .vcount(f_v), .hcount(f_h),
    .hblank(f_hb), .vblank(f_vb), .pixel_en(f_pix), .irq_vblank(f_iv),
    .irq_hblank(f_ih), .irq_vcount(f_ic));

  lcd_timing u_def (
    .clk_mem(clk_mem), .reset(reset_a), .dispcnt(dispcnt), .dispstat_wr(dispstat_wr),
    .dispstat_wdata(dispstat_wdata), .dispstat(d_ds), .vcount(d_v), .hcount(d_h),
    .hblank(d_hb), .vblank(d_vb), .pixel_en(d_pix), .irq_vblank(d_iv),
    .irq_hblank(d_ih), .irq_vcount(d_ic));

  lcd_timing #(.TICK_DIV(1), .DOT_TICKS(1)) u_rst (
    .clk_mem(clk_mem), .reset(reset_b), .dispcnt(dispcnt), .dispstat_wr(dispstat_wr),
    .dispstat_wdata(dispstat_wdata), .dispstat(r_ds), .vcount(r_v), .hcount(r_h),
    .hblank(r_hb), .vblank(r_vb), .pixel_en(r_pix), .irq_vblank(r_iv),
    .irq_hblank(r_ih), .irq_vcount(r_ic));

  function automatic int hpos(int cyc, int td, int dt);
    return (cyc / (td * dt)) % 308;
  endfunction

  function automatic int vpos(int cyc, int td, int dt);
    return ((cyc / (td * dt)) / 308) % 228;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 20) $error("FAIL %s observed=%h expected=%h n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n     = 0;
    m_lyc = 8'd0;
    m_en  = 3'd0;
  endtask

  // Captures the pre-edge position, then applies the edge and any write.
  task automatic model_edge(input logic wr, input logic [15:0] wd);
    p_h     = hpos(n, 1, 1);
    p_v     = vpos(n, 1, 1);
    p_match = VC_EN && (p_v == int'(m_lyc));
    n++;
    if (wr) begin
      m_lyc = wd[15:8];
      m_en  = wd[5:3];
    end
    if (!VC_EN) begin
      m_lyc   = 8'd0;
      m_en[2] = 1'b0;
    end
  endtask

  task automatic check_all();
    int h, v;
    logic hb, vb, m;
    h  = hpos(n, 1, 1);
    v  = vpos(n, 1, 1);
    hb = (h >= 240);
    vb = (v >= 160) && (v <= 226);
    m  = VC_EN && (v == int'(m_lyc));
    chk("hcount", 16'(f_h), 16'(h));
    chk("vcount", 16'(f_v), 16'(v));
    chk("hblank", 16'(f_hb), 16'(hb));
    chk("vblank", 16'(f_vb), 16'(vb));
    chk("pixel_en", 16'(f_pix), 16'(!hb && !vb && !dispcnt[7]));
    chk("dispstat", f_ds, {m_lyc, 2'b00, m_en, m, hb, vb});
    chk("irq_vblank", 16'(f_iv), 16'(m_en[0] && p_v == 159 && v == 160));
    chk("irq_hblank", 16'(f_ih), 16'(m_en[1] && p_h == 239 && h == 240));
    chk("irq_vcount", 16'(f_ic), 16'(m_en[2] && m && !p_match));
  endtask

  task automatic cycle(input logic wr, input logic [15:0] wd, input logic [15:0] dc);
    dispstat_wr    = wr;
    dispstat_wdata = wd;
    dispcnt        = dc;
    @(posedge clk_mem);
    model_edge(wr, wd);
    #1;
    check_all();
  endtask

  initial begin
    reset_a        = 1'b1;
    reset_b        = 1'b1;
    dispstat_wr    = 1'b0;
    dispstat_wdata = 16'h0000;
    dispcnt        = 16'h0000;
    n              = 0;
    repeat (2) @(posedge clk_mem);
    #1;
    chk("rst_hcount", 16'(f_h), 16'd0);
    chk("rst_vcount", 16'(f_v), 16'd0);
    chk("rst_dispstat", f_ds, VC_EN ? 16'h0004 : 16'h0000);
    chk("rst_irqs", 16'({f_iv, f_ih, f_ic}), 16'd0);
    chk("rst_pixel_en_on", 16'(f_pix), 16'd1);
    dispcnt = 16'h0080;
    #1;
    chk("rst_pixel_en_off", 16'(f_pix), 16'd0);

    // Prelude: random DISPSTAT writes and dispcnt, default-divider instance spot checks.
    reset_a = 1'b0;
    model_reset();
    for (int i = 1; i <= 3696; i++) begin
      p_wr = ($urandom_range(0, 31) == 0);
      p_wd = 16'($urandom);
      cycle(p_wr, p_wd, 16'($urandom));
      if (i == 2879) begin
        chk("def_hcount_2879", 16'(d_h), 16'd239);
        chk("def_hblank_2879", 16'(d_hb), 16'd0);
      end
      if (i == 2880) begin
        chk("def_hcount_2880", 16'(d_h), 16'd240);
        chk("def_hblank_2880", 16'(d_hb), 16'd1);
      end
      if (i == 3696) begin
        chk("def_hcount_line", 16'(d_h), 16'd0);
        chk("def_vcount_line", 16'(d_v), 16'd1);
      end
    end

    // Full frame under forced blank, with lyc rewrites and a mid-vblank restart of u_rst.
    dispstat_wr = 1'b0;
    reset_a     = 1'b1;
    reset_b     = 1'b1;
    @(posedge clk_mem);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    model_reset();
    n_w50    = 50 * 308 + int'($urandom_range(10, 200));
    cnt_iv   = 0;
    cnt_ih   = 0;
    cnt_ic   = 0;
    cnt_pix  = 0;
    cnt_l100 = 0;
    cnt_rirq = 0;
    for (int i = 1; i <= FRAME; i++) begin
      p_wr = 1'b0;
      p_wd = 16'h0000;
      if (i == 1)            begin p_wr = 1'b1; p_wd = 16'h6438; end
      if (i == n_w50)        begin p_wr = 1'b1; p_wd = 16'h3238; end
      if (i == 60 * 308 + 5) begin p_wr = 1'b1; p_wd = 16'h6438; end
      reset_b = (i == N_RST);
      cycle(p_wr, p_wd, 16'($urandom) | 16'h0080);
      cnt_iv  += int'(f_iv);
      cnt_ih  += int'(f_ih);
      cnt_ic  += int'(f_ic);
      cnt_pix += int'(f_pix);
      if (vpos(n, 1, 1) == 100) cnt_l100 += int'(f_ds[2]);
      if (i == n_w50) chk("lyc_write_irq", 16'(f_ic), 16'(VC_EN));
      if (i == 227 * 308 + 3) begin
        chk("line227_vcount", 16'(f_v), 16'd227);
        chk("line227_vblank", 16'(f_vb), 16'd0);
      end
      if (i == N_RST - 1) begin
        chk("pre_rst_vcount", 16'(r_v), 16'd170);
        chk("pre_rst_vblank", 16'(r_vb), 16'd1);
      end
      if (i == N_RST) begin
        chk("post_rst_vblank", 16'(r_vb), 16'd0);
        chk("post_rst_pos", {r_v, 7'd0, r_h[0]} | 16'(r_h), 16'd0);
        chk("post_rst_dispstat", r_ds, VC_EN ? 16'h0004 : 16'h0000);
      end
      if (i >= N_RST && i <= N_RST + 400) cnt_rirq += int'(r_iv) + int'(r_ih) + int'(r_ic);
      if (i == N_RST + 400) begin
        chk("restart_irqs", 16'(cnt_rirq), 16'd0);
        chk("restart_hcount", 16'(r_h), 16'd92);
        chk("restart_vcount", 16'(r_v), 16'd1);
      end
    end
    chk("frame_vcount", 16'(f_v), 16'd0);
    chk("frame_hcount", 16'(f_h), 16'd0);
    chk("frame_irq_vblank_cnt", 16'(cnt_iv), 16'd1);
    chk("frame_irq_hblank_cnt", 16'(cnt_ih), 16'd228);
    chk("frame_irq_vcount_cnt", 16'(cnt_ic), VC_EN ? 16'd2 : 16'd0);
    chk("frame_pixel_en_cnt", 16'(cnt_pix), 16'd0);
    chk("line100_match_cnt", 16'(cnt_l100), VC_EN ? 16'd308 : 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_timing.md
LCD_TIMING -- requirements
Module: lcd_timing

Interface
REQ-001 SHALL have parameter TICK_DIV, default 3: clk_mem cycles per 16.7 MHz system tick.
REQ-002 SHALL have parameter DOT_TICKS, default 4: system ticks per dot.
REQ-003 SHALL have port clk_mem  input  1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port dispcnt  input  16: display control; bit 7 is forced blank.
REQ-006 SHALL have port dispstat_wr  input  1: one-cycle write strobe for DISPSTAT.
REQ-007 SHALL have port dispstat_wdata  input  16: DISPSTAT write data.
REQ-008 SHALL have port dispstat  output  16: DISPSTAT readback.
REQ-009 SHALL have port vcount  output  8: current line, 0..227.
REQ-010 SHALL have port hcount  output  9: current dot, 0..307.
REQ-011 SHALL have ports hblank and vblank  output  1 each: blanking flags.
REQ-012 SHALL have port pixel_en  output  1: high when the renderer fetches and outputs the current dot.
REQ-013 SHALL have ports irq_vblank, irq_hblank and irq_vcount  output  1 each: one-cycle interrupt request pulses.

Function
REQ-014 SHALL count clk_mem cycles 0..TICK_DIV-1 and assert an internal tick on the wrap cycle.
REQ-015 SHALL count ticks 0..DOT_TICKS-1 and advance hcount by one on the wrap tick.
REQ-016 SHALL wrap hcount from 307 to 0 and increment vcount in the same cycle; vcount SHALL wrap from 227 to 0.
REQ-017 SHALL drive hblank = (hcount >= 240).
REQ-018 SHALL drive vblank = (vcount >= 160 && vcount <= 226); line 227 SHALL read vblank = 0.
REQ-019 SHALL drive pixel_en = !hblank && !vblank && !dispcnt[7]; forced blank SHALL NOT stall the counters.
REQ-020 SHALL present dispstat as {lyc[7:0], 2'b0, irq enables[5:3], vcount_match, hblank, vblank}.
REQ-021 SHALL, on dispstat_wr, update only bits 15:8 and 5:3; bits 2:0 SHALL be read-only.
REQ-022 SHALL pulse irq_vblank for one clk_mem cycle when vcount changes 159->160 and enable bit 3 = 1.
REQ-023 SHALL pulse irq_hblank for one clk_mem cycle when hcount changes 239->240 and enable bit 4 = 1, on every line including vblank lines.
REQ-024 SHALL set vcount_match = (vcount == lyc), combinationally from registered values.
REQ-025 SHALL pulse irq_vcount for one cycle on the rising edge of vcount_match when enable bit 5 = 1.
REQ-026 SHALL raise irq_vcount on the next cycle when a DISPSTAT write changes lyc to equal the current vcount (bit 5 = 1).
REQ-027 SHALL apply a DISPSTAT write that coincides with a line change before evaluating the match, so the write wins.
REQ-028 SHALL update all outputs registered, except dispstat bits 2:0 and pixel_en, which are combinational from registers.

Reset
REQ-029 SHALL, on reset, clear both dividers, hcount, vcount, lyc, the irq enables and all irq outputs to 0.
REQ-030 SHALL read dispstat = 16'h0004 after reset (lyc 0 matches line 0) and pixel_en = !dispcnt[7].
REQ-031 SHALL treat reset asserted mid-frame as immediately restarting at dot 0, line 0, with no irq pulse generated by the restart.

Configuration
REQ-032 SHALL, with LCD_VCOUNT_IRQ_EN defined, implement the lyc compare and irq_vcount as specified above.
REQ-033 SHALL, with LCD_VCOUNT_IRQ_EN undefined, omit the compare logic, tie irq_vcount to 0 and read dispstat bits 15:8, 5 and 2 as 0.

Structure
REQ-034 SHALL place H_VISIBLE=240, H_TOTAL=308, V_VISIBLE=160, V_TOTAL=228 and the DISPSTAT bit-index constants in shared package lcd_pkg.
REQ-035 SHALL implement the clk_mem-to-tick divider as sub-module tick_div, parameterised by TICK_DIV, so it is reusable by the timers.

Verification
REQ-036 SHALL verify: reset, then run 3*4*308 = 3696 cycles -> hcount 0, vcount 1; hblank rises at cycle 2880.
REQ-037 SHALL verify: run one full frame of 3696*228 = 842688 cycles -> exactly one irq_vblank pulse at line 160; vblank low on line 227; vcount back at 0.
REQ-038 SHALL verify: write dispstat_wdata = 16'h6420 -> irq_vcount pulses once at line 100 (0x64); dispstat bit 2 is high for the whole of line 100.
REQ-039 SHALL verify: at vcount = 50, write lyc = 50 with bit 5 = 1 -> irq_vcount pulses on the next cycle.
REQ-040 SHALL verify: dispcnt = 16'h0080 -> pixel_en stays 0 for the whole frame while hcount and vcount keep advancing.
REQ-041 SHALL verify: assert reset at line 170 -> vblank drops on the next cycle and no irq pulses are emitted.
